mips_multicycle_ctrl: RTL and testbench

Main control unit for the multicycle MIPS core. A Moore state machine decodes the instruction register's opcode and funct fields. Each cycle it drives the select lines of the datapath multiplexers (the 2:1 and 4:1 operand, address and PC-source muxes), the register, memory and PC write enables, and the ALU control code. Memory accesses stall on a ready handshake.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 44 ++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct constants and ALU control codes.
package mips_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's alu_op and the R-type funct field to alu_ctl,
// flagging funct codes the datapath does not implement.
module mips_alu_decoder
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctl,
   output logic       funct_illegal
);

   always_comb begin
      alu_ctl       = ALU_ADD;
      funct_illegal = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_ctl = ALU_ADD;
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               // Unknown funct still executes as an add so the instruction completes.
               default: funct_illegal = 1'b1;
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: Moore FSM driving datapath mux selects,
// write enables and ALU control, with memory stalls on mem_ready.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_ctl,
   output logic       pc_en,
   output logic       illegal,
   output logic [3:0] state
);

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       alu_en;
   logic       pc_write;
   logic       branch;
   logic       op_illegal;
   logic [2:0] dec_ctl;
   logic       fn_illegal;

   mips_alu_decoder u_alu_dec (
      .alu_op        (alu_op),
      .funct         (funct),
      .alu_ctl       (dec_ctl),
      .funct_illegal (fn_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = ALUOP_ADD;
      alu_en     = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      op_illegal = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            alu_src_b = 2'b01;
            alu_en    = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_en    = 1'b1;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d    = S_FETCH;
                  op_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_en    = 1'b1;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            alu_en    = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            alu_en    = 1'b1;
            pc_src    = 2'b01;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_en    = 1'b1;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // States that do not use the ALU present alu_ctl as 000 rather than add.
   assign alu_ctl = alu_en ? dec_ctl : 3'b000;
   assign pc_en   = pc_write | (branch & zero);
   assign illegal = op_illegal | ((state_q == S_EXEC) & fn_illegal);
   assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: instruction-level model expands each instruction into
// its expected per-cycle state and control word, compared against the DUT.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'b100011;
   logic [5:0] funct = 6'b000000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctl;
   logic       pc_en, illegal;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_ctl(alu_ctl), .pc_en(pc_en), .illegal(illegal), .state(state)
   );

   logic [15:0] obs_word;
   assign obs_word = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                      alu_src_a, alu_src_b, pc_src, alu_ctl, pc_en, illegal};

   localparam logic [15:0] W_IORD = 16'h8000, W_MW = 16'h4000, W_IRW = 16'h2000;
   localparam logic [15:0] W_RD = 16'h1000, W_M2R = 16'h0800, W_RW = 16'h0400;
   localparam logic [15:0] W_SRCA = 16'h0200, W_PCEN = 16'h0002, W_ILL = 16'h0001;
   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_BAD = 6;

   typedef struct {
      logic [3:0]  st;
      logic        rdy;
      logic        zf;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] word;
   } cyc_t;

   cyc_t trace[$];
   int checks = 0;
   int errors = 0;
   logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   function automatic logic [15:0] w_srcb(input logic [1:0] v);
      return {7'b0, v, 7'b0};
   endfunction
   function automatic logic [15:0] w_pcsrc(input logic [1:0] v);
      return {9'b0, v, 5'b0};
   endfunction
   function automatic logic [15:0] w_alu(input logic [2:0] v);
      return {11'b0, v, 2'b0};
   endfunction
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // R-type funct table: {illegal, alu_ctl}
   function automatic logic [3:0] r_model(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         default:   return 4'b1010;
      endcase
   endfunction

   function automatic bit known_op(input logic [5:0] op);
      return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input logic zf,
                       input logic [5:0] op, input logic [5:0] fn, input logic [15:0] w);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.zf = zf; c.op = op; c.fn = fn; c.word = w;
      trace.push_back(c);
   endtask

   // Expand one instruction into expected cycles (fetch stalls, memory stalls).
   task automatic plan(input int cls, input logic [5:0] fn, input logic zf,
                       input int f_st, input int m_st);
      logic [5:0] op;
      logic [3:0] r;
      case (cls)
         C_LW:    op = 6'b100011;
         C_SW:    op = 6'b101011;
         C_R:     op = 6'b000000;
         C_BEQ:   op = 6'b000100;
         C_ADDI:  op = 6'b001000;
         C_J:     op = 6'b000010;
         default: begin
            op = 6'($urandom);
            while (known_op(op)) op = 6'($urandom);
         end
      endcase
      for (int i = 0; i < f_st; i++) push(4'd1, 1'b0, rb(), op, fn, w_srcb(2'b01) | w_alu(3'b010));
      push(4'd1, 1'b1, rb(), op, fn, W_IRW | W_PCEN | w_srcb(2'b01) | w_alu(3'b010));
      push(4'd2, rb(), rb(), op, fn, w_srcb(2'b11) | w_alu(3'b010) | ((cls == C_BAD) ? W_ILL : 16'h0));
      case (cls)
         C_LW: begin
            push(4'd3, rb(), rb(), op, fn, W_SRCA | w_srcb(2'b10) | w_alu(3'b010));
            for (int i = 0; i < m_st; i++) push(4'd4, 1'b0, rb(), op, fn, W_IORD);
            push(4'd4, 1'b1, rb(), op, fn, W_IORD);
            push(4'd5, rb(), rb(), op, fn, W_M2R | W_RW);
         end
         C_SW: begin
            push(4'd3, rb(), rb(), op, fn, W_SRCA | w_srcb(2'b10) | w_alu(3'b010));
            for (int i = 0; i < m_st; i++) push(4'd6, 1'b0, rb(), op, fn, W_IORD | W_MW);
            push(4'd6, 1'b1, rb(), op, fn, W_IORD | W_MW);
         end
         C_R: begin
            r = r_model(fn);
            push(4'd7, rb(), rb(), op, fn, W_SRCA | w_alu(r[2:0]) | (r[3] ? W_ILL : 16'h0));
            push(4'd8, rb(), rb(), op, fn, W_RD | W_RW);
         end
         C_BEQ: push(4'd9, rb(), zf, op, fn,
                     W_SRCA | w_alu(3'b110) | w_pcsrc(2'b01) | (zf ? W_PCEN : 16'h0));
         C_ADDI: begin
            push(4'd10, rb(), rb(), op, fn, W_SRCA | w_srcb(2'b10) | w_alu(3'b010));
            push(4'd11, rb(), rb(), op, fn, W_RW);
         end
         C_J: push(4'd12, rb(), rb(), op, fn, w_pcsrc(2'b10) | W_PCEN);
         default: ;
      endcase
   endtask

   task automatic apply(input cyc_t c, output logic [15:0] w, output logic [3:0] s);
      @(negedge clk);
      mem_ready = c.rdy; zero = c.zf; opcode = c.op; funct = c.fn;
      #1;
      w = obs_word; s = state;
   endtask

   task automatic test_reset();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      rst = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if (state !== 4'd0 || obs_word !== 16'h0)
            begin errors++; $display("FAIL reset_hold state=%0d word=%h required state=0 word=0000", state, obs_word); end
      end
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (state !== 4'd0 || obs_word !== 16'h0)
         begin errors++; $display("FAIL reset_idle state=%0d word=%h required state=0 word=0000", state, obs_word); end
      plan(C_J, 6'd0, 1'b0, 0, 0);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL reset_first_fetch state=%0d word=%h required state=%0d word=%h", s, w, c.st, c.word); end
      end
   endtask

   task automatic test_mem_access();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      int mw_cnt, rw_cnt;
      plan(C_LW, 6'($urandom), 1'b0, 0, 0);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL lw state=%0d word=%h required state=%0d word=%h", s, w, c.st, c.word); end
      end
      mw_cnt = 0; rw_cnt = 0;
      plan(C_SW, 6'($urandom), 1'b0, 0, 2);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         mw_cnt += int'(mem_write);
         rw_cnt += int'(reg_write);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL sw_stall state=%0d word=%h required state=%0d word=%h", s, w, c.st, c.word); end
      end
      checks++;
      if (mw_cnt !== 3 || rw_cnt !== 0)
         begin errors++; $display("FAIL sw_strobes mem_write_cycles=%0d reg_write_cycles=%0d required 3 and 0", mw_cnt, rw_cnt); end
   endtask

   task automatic test_alu_ops();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      plan(C_R, 6'b101010, 1'b0, 0, 0);
      plan(C_R, 6'b111111, 1'b0, 0, 0);
      plan(C_ADDI, 6'($urandom), 1'b0, 1, 0);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL alu_ops fn=%b state=%0d word=%h required state=%0d word=%h", c.fn, s, w, c.st, c.word); end
      end
   endtask

   task automatic test_branch_jump();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      plan(C_BEQ, 6'($urandom), 1'b1, 0, 0);
      plan(C_BEQ, 6'($urandom), 1'b0, 0, 0);
      plan(C_J, 6'($urandom), 1'b0, 0, 0);
      plan(C_BAD, 6'($urandom), 1'b0, 0, 0);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL branch_jump op=%b state=%0d word=%h required state=%0d word=%h", c.op, s, w, c.st, c.word); end
      end
   endtask

   task automatic test_random();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      logic [5:0] fn;
      int cls;
      for (int n = 0; n < 250; n++) begin
         cls = int'($urandom_range(0, 6));
         fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
         plan(cls, fn, rb(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
              int'($urandom_range(0, 2)));
      end
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL random op=%b fn=%b state=%0d word=%h required state=%0d word=%h", c.op, c.fn, s, w, c.st, c.word); end
      end
   endtask

   task automatic test_reset_mid();
      cyc_t c;
      logic [15:0] w;
      logic [3:0] s;
      bit in_memwr;
      in_memwr = 1'b0;
      plan(C_SW, 6'($urandom), 1'b0, 0, 3);
      while (trace.size() > 0 && !in_memwr) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL reset_mid_pre state=%0d word=%h required state=%0d word=%h", s, w, c.st, c.word); end
         in_memwr = (c.st == 4'd6);
      end
      trace.delete();
      rst = 1'b1;
      #1;
      checks++;
      if (mem_write !== 1'b0 || state !== 4'd0 || obs_word !== 16'h0)
         begin errors++; $display("FAIL reset_mid mem_write=%b state=%0d word=%h required 0 0 0000", mem_write, state, obs_word); end
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (state !== 4'd0 || obs_word !== 16'h0)
         begin errors++; $display("FAIL reset_mid_idle state=%0d word=%h required state=0 word=0000", state, obs_word); end
      plan(C_ADDI, 6'd0, 1'b0, 0, 0);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply(c, w, s);
         checks++;
         if (s !== c.st || w !== c.word)
            begin errors++; $display("FAIL reset_mid_post state=%0d word=%h required state=%0d word=%h", s, w, c.st, c.word); end
      end
   endtask

   initial begin
      test_reset();
      test_mem_access();
      test_alu_ops();
      test_branch_jump();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
